// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the async_fifo write-port arbiter.
package fifo_wr_arb_pkg;

   typedef enum logic {IDLE, BURST} arb_state_t;

   localparam int unsigned STATS_W = 16;

   // Converts a one-hot vector (up to 16 bits) into its bit index; zero input gives 0.
   function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (onehot[i]) begin
            idx = idx | 4'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Round-robin priority search: first asserted request strictly after rr_last, wrapping.
module rr_priority_picker #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_last,
   output logic [IDX_W-1:0]   pick,
   output logic               any_req
);

   always_comb begin
      int unsigned idx;
      idx  = 0;
      pick = '0;
      // Walk from the farthest candidate back to the nearest so the nearest wins.
      for (int unsigned i = NUM_REQ; i >= 1; i--) begin
         idx = (32'(rr_last) + i) % NUM_REQ;
         if (req[idx]) begin
            pick = IDX_W'(idx);
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the async_fifo write port among NUM_REQ streams.
// Optional per-requester beat and stall statistics when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_BURST  = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STATS_W-1:0]    beat_count,
   output logic [STATS_W-1:0]            stall_count
`endif
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t             state;
   logic [IDX_W-1:0]       rr_last;
   logic [CNT_W-1:0]       beat_cnt;
   logic [IDX_W-1:0]       pick;
   logic                   any_req;
   logic [IDX_W-1:0]       owner;
   logic                   beat;
   logic                   burst_end;
   logic [DATA_WIDTH-1:0]  req_words [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req     (req_valid),
      .rr_last (rr_last),
      .pick    (pick),
      .any_req (any_req)
   );

   assign owner        = IDX_W'(onehot_to_idx(16'(grant)));
   assign busy         = (state == BURST);
   assign beat         = busy & req_valid[owner] & ~fifo_full;
   assign fifo_wr_en   = beat;
   assign fifo_wr_data = busy ? req_words[owner] : '0;

   always_comb begin
      req_ready        = '0;
      req_ready[owner] = beat;
   end

   // Burst-length exit takes priority over counting so beat_cnt never wraps.
   assign burst_end = (beat & (req_last[owner] | (beat_cnt == CNT_W'(MAX_BURST - 1))))
                    | (busy & ~req_valid[owner]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         grant    <= '0;
         rr_last  <= IDX_W'(NUM_REQ - 1);
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state    <= BURST;
                  grant    <= NUM_REQ'(1) << pick;
                  rr_last  <= pick;
                  beat_cnt <= '0;
               end
            end
            BURST: begin
               if (beat) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
               if (burst_end) begin
                  state <= IDLE;
                  grant <= '0;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STATS_W-1:0] per_req_beats [NUM_REQ];
   logic               stall;

   assign stall = busy & req_valid[owner] & fifo_full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            per_req_beats[i] <= '0;
         end
         stall_count <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (beat && (owner == IDX_W'(i)) && (per_req_beats[i] != '1)) begin
               per_req_beats[i] <= per_req_beats[i] + STATS_W'(1);
            end
         end
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + STATS_W'(1);
         end
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
      assign beat_count[i*STATS_W +: STATS_W] = per_req_beats[i];
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stream sources per requester, expected beats in a queue.
module tb_fifo_wr_arbiter;

   localparam int DW = 32;
   localparam int NR = 4;
   localparam int MB = 8;

   logic              clk;
   logic              reset_n;
   logic [NR-1:0]     req_valid, req_last, req_ready, grant;
   logic [NR*DW-1:0]  req_data;
   logic              fifo_full, fifo_wr_en, busy;
   logic [DW-1:0]     fifo_wr_data;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [NR*16-1:0]  beat_count;
   logic [15:0]       stall_count;
`endif

   logic [DW-1:0] sb [$];
   int            n_checks = 0;
   int            n_pass   = 0;
   logic [NR-1:0] acc      = '0;
   logic [NR-1:0] src_active;
   int            src_cnt [NR];
   int            src_len [NR];

   fifo_wr_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_REQ    (NR),
      .MAX_BURST  (MB)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .grant        (grant),
      .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .beat_count   (beat_count),
      .stall_count  (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pat(input int r, input int c);
      return {r[7:0], c[23:0]};
   endfunction

   // Each source presents beat src_cnt with data pat(i, src_cnt); len 0 means never last.
   always_comb begin
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      for (int i = 0; i < NR; i++) begin
         req_valid[i]          = src_active[i];
         req_last[i]           = (src_len[i] != 0) && (src_cnt[i] == src_len[i] - 1);
         req_data[i*DW +: DW]  = pat(i, src_cnt[i]);
      end
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NR; i++) begin
         if (acc[i]) begin
            src_cnt[i] = src_cnt[i] + 1;
            if (src_len[i] != 0 && src_cnt[i] == src_len[i]) src_active[i] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      logic [DW-1:0] exp_d;
      acc = req_valid & req_ready;
      if (reset_n === 1'b1 && fifo_wr_en === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected_write: got data %h, required no write", fifo_wr_data);
         end else begin
            exp_d = sb.pop_front();
            if (fifo_wr_data !== exp_d)
               $display("FAIL sb_data: got %h required %h", fifo_wr_data, exp_d);
            else n_pass++;
         end
      end
   end

   task automatic test_reset();
      #3;
      n_checks++;
      if ({grant, busy, fifo_wr_en, req_ready, fifo_wr_data} !== '0)
         $display("FAIL reset_outputs: got %b/%b/%b/%b/%h required all zero",
                  grant, busy, fifo_wr_en, req_ready, fifo_wr_data);
      else n_pass++;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({grant, busy, fifo_wr_en} !== '0)
         $display("FAIL idle_after_reset: got grant %b busy %b wr_en %b required 0",
                  grant, busy, fifo_wr_en);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [NR-1:0] prev;
      logic [NR-1:0] seen [5];
      int            beats_in [5];
      int            ngr, gap, total;
      bit            done;
      prev = '0; ngr = 0; gap = 0; total = 0; done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         seen[k] = '0;
         beats_in[k] = 0;
      end
      for (int g = 0; g < 5; g++)
         for (int b = 0; b < MB; b++) sb.push_back(pat(g % NR, (g / NR) * MB + b));
      @(posedge clk);
      #2;
      for (int i = 0; i < NR; i++) begin
         src_cnt[i] = 0;
         src_len[i] = 0;
      end
      src_active = '1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (grant !== prev && grant !== '0) begin
            if (ngr > 0) begin
               n_checks++;
               if (gap !== 1) $display("FAIL rr_bubble: got %0d idle cycles required 1", gap);
               else n_pass++;
            end
            if (ngr < 5) seen[ngr] = grant;
            ngr++;
            gap = 0;
         end
         prev = grant;
         if (grant === '0) gap++;
         else if (fifo_wr_en === 1'b1) begin
            if (ngr <= 5) beats_in[ngr-1]++;
            total++;
         end
         if (done && grant === '0) break;
         if (!done && total == 5 * MB) begin
            @(posedge clk);
            #2 src_active = '0;
            done = 1'b1;
         end
      end
      n_checks++;
      if (!done) $display("FAIL rr_timeout: got %0d beats required %0d", total, 5 * MB);
      else n_pass++;
      n_checks++;
      if (ngr !== 5) $display("FAIL rr_grant_count: got %0d required 5", ngr);
      else n_pass++;
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (seen[k] !== (NR'(1) << (k % NR)))
            $display("FAIL rr_order[%0d]: got %b required %b", k, seen[k], NR'(1) << (k % NR));
         else n_pass++;
         n_checks++;
         if (beats_in[k] !== MB)
            $display("FAIL rr_burst_len[%0d]: got %0d required %0d", k, beats_in[k], MB);
         else n_pass++;
      end
   endtask

   task automatic test_single();
      src_cnt[0] = 0;
      src_len[0] = 3;
      for (int b = 0; b < 3; b++) sb.push_back(pat(0, b));
      @(posedge clk);
      #2 src_active = 4'b0001;
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0000) $display("FAIL single_no_grant_yet: got %b required 0000", grant);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0001) $display("FAIL single_grant: got %b required 0001", grant);
      else n_pass++;
      for (int b = 0; b < 3; b++) begin
         if (b > 0) @(negedge clk);
         n_checks++;
         if ({fifo_wr_en, req_ready} !== 5'b1_0001)
            $display("FAIL single_beat[%0d]: got wr_en %b ready %b required 1 0001",
                     b, fifo_wr_en, req_ready);
         else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if ({grant, busy, fifo_wr_en} !== 6'b0)
         $display("FAIL single_idle_after: got grant %b busy %b wr_en %b required 0",
                  grant, busy, fifo_wr_en);
      else n_pass++;
      @(posedge clk);
      #2;
      n_checks++;
      if (sb.size() != 0) $display("FAIL single_drain: got %0d pending required 0", sb.size());
      else n_pass++;
   endtask

   task automatic test_stall();
      int resumed;
      bit ok;
      src_cnt[2] = 0;
      src_len[2] = 12;
      for (int b = 0; b < 12; b++) sb.push_back(pat(2, b));
      @(posedge clk);
      #2 src_active = 4'b0100;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #2;
         if (src_cnt[2] >= 3) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok) $display("FAIL stall_start_timeout: got %0d beats required 3", src_cnt[2]);
      else n_pass++;
      fifo_full = 1'b1;
      repeat (5) begin
         @(negedge clk);
         n_checks++;
         if ({fifo_wr_en, req_ready, grant} !== 9'b0_0000_0100)
            $display("FAIL stall_hold: got wr_en %b ready %b grant %b required 0 0000 0100",
                     fifo_wr_en, req_ready, grant);
         else n_pass++;
      end
      @(posedge clk);
      #2 fifo_full = 1'b0;
      resumed = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (grant === '0) break;
         if (fifo_wr_en === 1'b1) resumed++;
      end
      n_checks++;
      if (resumed !== MB - 3)
         $display("FAIL stall_resume_beats: got %0d required %0d", resumed, MB - 3);
      else n_pass++;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #2;
         if (src_active == '0 && grant == '0) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok || sb.size() != 0)
         $display("FAIL stall_drain: got done %b pending %0d required 1 0", ok, sb.size());
      else n_pass++;
   endtask

   task automatic test_abandon();
      bit ok;
      src_cnt[1] = 0; src_len[1] = 0;
      src_cnt[0] = 0; src_len[0] = 1;
      src_cnt[3] = 0; src_len[3] = 1;
      sb.push_back(pat(1, 0));
      sb.push_back(pat(1, 1));
      sb.push_back(pat(3, 0));
      sb.push_back(pat(0, 0));
      @(posedge clk);
      #2 src_active = 4'b0010;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #2;
         if (src_cnt[1] >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok) $display("FAIL abandon_start_timeout: got %0d beats required 2", src_cnt[1]);
      else n_pass++;
      src_active = 4'b1001;
      @(negedge clk);
      n_checks++;
      if ({grant, fifo_wr_en} !== 5'b0010_0)
         $display("FAIL abandon_no_beat: got grant %b wr_en %b required 0010 0",
                  grant, fifo_wr_en);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({grant, busy} !== 5'b0)
         $display("FAIL abandon_idle: got grant %b busy %b required 0000 0", grant, busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b1000) $display("FAIL abandon_next_pick: got %b required 1000", grant);
      else n_pass++;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #2;
         if (src_active == '0 && grant == '0) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok || sb.size() != 0)
         $display("FAIL abandon_drain: got done %b pending %0d required 1 0", ok, sb.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      src_cnt[2] = 0;
      src_len[2] = 0;
      for (int b = 0; b < 20; b++) sb.push_back(pat(2, b));
      @(posedge clk);
      #2 src_active = 4'b0100;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #2;
         if (src_cnt[2] >= 3) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok || {busy, grant} !== 5'b1_0100)
         $display("FAIL rstmid_in_burst: got busy %b grant %b required 1 0100", busy, grant);
      else n_pass++;
      #1 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({grant, busy, fifo_wr_en, req_ready, fifo_wr_data} !== '0)
         $display("FAIL rstmid_async_clear: got %b/%b/%b/%b/%h required all zero",
                  grant, busy, fifo_wr_en, req_ready, fifo_wr_data);
      else n_pass++;
      sb.delete();
      src_active = '0;
      for (int i = 0; i < NR; i++) src_cnt[i] = 0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      src_len[0] = 1;
      src_len[3] = 1;
      sb.push_back(pat(0, 0));
      sb.push_back(pat(3, 0));
      src_active = 4'b1001;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (grant !== 4'b0001) $display("FAIL rstmid_first_pick: got %b required 0001", grant);
      else n_pass++;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #2;
         if (src_active == '0 && grant == '0) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok || sb.size() != 0)
         $display("FAIL rstmid_drain: got done %b pending %0d required 1 0", ok, sb.size());
      else n_pass++;
   endtask

`ifdef FIFO_WR_ARB_STATS_EN
   task automatic test_stats();
      bit ok;
      for (int c = 0; c < 70000; c++) sb.push_back(pat(0, c));
      @(posedge clk);
      #2;
      src_cnt[0] = 0;
      src_len[0] = 0;
      fifo_full  = 1'b1;
      src_active = 4'b0001;
      // One IDLE cycle plus five stalled BURST cycles.
      repeat (6) @(posedge clk);
      #2 fifo_full = 1'b0;
      @(negedge clk);
      n_checks++;
      if (stall_count !== 16'd5) $display("FAIL stats_stall: got %0d required 5", stall_count);
      else n_pass++;
      ok = 1'b0;
      for (int c = 0; c < 90000; c++) begin
         @(posedge clk);
         #2;
         if (src_cnt[0] >= 70000) begin
            ok = 1'b1;
            break;
         end
      end
      src_active = '0;
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (!ok || sb.size() != 0)
         $display("FAIL stats_stream: got done %b pending %0d required 1 0", ok, sb.size());
      else n_pass++;
      n_checks++;
      if (beat_count[15:0] !== 16'hFFFF)
         $display("FAIL stats_beat_sat: got %h required ffff", beat_count[15:0]);
      else n_pass++;
      n_checks++;
      if (stall_count !== 16'd5)
         $display("FAIL stats_stall_hold: got %0d required 5", stall_count);
      else n_pass++;
   endtask
`endif

   initial begin
      reset_n    = 1'b0;
      fifo_full  = 1'b0;
      src_active = '0;
      for (int i = 0; i < NR; i++) begin
         src_cnt[i] = 0;
         src_len[i] = 0;
      end
      test_reset();
      test_round_robin();
      test_single();
      test_stall();
      test_abandon();
      test_reset_mid();
`ifdef FIFO_WR_ARB_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
